// File: rtl/io_run_ctrl.sv
// io_run_ctrl: memory-mapped run controller for a soft CPU.
//
// Decodes a small IO register window (selected by a[IO_BIT]) and generates the
// CPU clock enable in one of four modes: free-run, divided, single-step, paused.
// It also keeps a saturating executed-cycle counter, a LED register and a sticky
// end-of-program flag.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   a, wd, we    CPU data address, store data, store strobe
//   rd           IO read data, combinational from a
//   is_io        a[IO_BIT]; used outside to gate the RAM write enable
//   sw           raw board switches (synchronised here)
//   step_key     raw single-step button, active-high (synchronised here)
//   endcontrol   CPU end-of-program flag
//   cpu_en       CPU clock enable
//   led          LED register
//   cycle_count  executed-cycle counter
//   done         sticky end-of-program flag
//
// Register map (offset a[4:2], only when is_io=1):
//   0 SW (RO), 1 LED (RW), 2 CYCLE (RO, write clears), 3 CTRL (RW, bits[1:0] mode),
//   4 STATUS (RO, bit0 done, bit1 step_pending), 5-7 read as 0.
module io_run_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SW_W     = 10,
    parameter int unsigned LED_W    = 10,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DIV      = 50000000,
    parameter int unsigned IO_BIT   = 8,
    parameter logic [1:0]  MODE_RST = 2'b00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] rd,
    output logic              is_io,
    input  logic [SW_W-1:0]   sw,
    input  logic              step_key,
    input  logic              endcontrol,
    output logic              cpu_en,
    output logic [LED_W-1:0]  led,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done
);

    typedef enum logic [1:0] {
        ModeFree  = 2'b00,
        ModeDiv   = 2'b01,
        ModeStep  = 2'b10,
        ModePause = 2'b11
    } mode_e;

    localparam int unsigned      DivW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0]  DivMax    = DivW'(DIV - 1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [2:0]       OffSw     = 3'd0;
    localparam logic [2:0]       OffLed    = 3'd1;
    localparam logic [2:0]       OffCycle  = 3'd2;
    localparam logic [2:0]       OffCtrl   = 3'd3;
    localparam logic [2:0]       OffStatus = 3'd4;

    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic             step_s1_q, step_s2_q, step_s3_q;
    mode_e            mode_q, mode_d;
    logic [DivW-1:0]  div_q, div_d;
    logic             step_pending_q, step_pending_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic io_wr, wr_led, wr_cycle, wr_ctrl;
    logic step_edge, step_fire;
    logic unused_bits;

    assign is_io       = a[IO_BIT];
    // Reset forces the enable low in the same cycle, not just after the edge.
    assign cpu_en      = en_q & ~reset;
    assign led         = led_q;
    assign cycle_count = cnt_q;
    assign done        = done_q;
    assign unused_bits = ^{a, wd};

    // Register decode and next-state logic.
    always_comb begin
        io_wr    = we & is_io & cpu_en;
        wr_led   = io_wr & (a[4:2] == OffLed);
        wr_cycle = io_wr & (a[4:2] == OffCycle);
        wr_ctrl  = io_wr & (a[4:2] == OffCtrl);

        step_edge = step_s2_q & ~step_s3_q;
        step_fire = (mode_q == ModeStep) & step_pending_q;

        mode_d = wr_ctrl ? mode_e'(wd[1:0]) : mode_q;
        led_d  = wr_led ? wd[LED_W-1:0] : led_q;
        done_d = done_q | endcontrol;

        if (wr_ctrl || (div_q == DivMax)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DivW'(1);
        end

        // Edges outside single-step mode are dropped; a pending step is consumed
        // by the enable pulse it produces.
        if (wr_ctrl) begin
            step_pending_d = 1'b0;
        end else if (step_edge && (mode_q == ModeStep)) begin
            step_pending_d = 1'b1;
        end else if (step_fire) begin
            step_pending_d = 1'b0;
        end else begin
            step_pending_d = step_pending_q;
        end

        // Enable for the next cycle is derived from next-state values so that a
        // CTRL write governs cpu_en from the very next cycle.
        en_d = 1'b0;
        case (mode_d)
            ModeFree:  en_d = 1'b1;
            ModeDiv:   en_d = (div_d == DivMax);
            ModeStep:  en_d = step_fire & ~wr_ctrl;
            default:   en_d = 1'b0;
        endcase
        if (done_d) begin
            en_d = 1'b0;
        end

        // Clear wins over increment; saturate instead of wrapping.
        cnt_d = cnt_q;
        if (wr_cycle) begin
            cnt_d = '0;
        end else if (cpu_en && !endcontrol && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // IO read mux.
    always_comb begin
        rd = '0;
        if (is_io) begin
            case (a[4:2])
                OffSw:     rd = DATA_W'(sw_s2_q);
                OffLed:    rd = DATA_W'(led_q);
                OffCycle:  rd = DATA_W'(cnt_q);
                OffCtrl:   rd = DATA_W'(mode_q);
                OffStatus: rd = DATA_W'({step_pending_q, done_q});
                default:   rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q        <= '0;
            sw_s2_q        <= '0;
            step_s1_q      <= 1'b0;
            step_s2_q      <= 1'b0;
            step_s3_q      <= 1'b0;
            mode_q         <= mode_e'(MODE_RST);
            div_q          <= '0;
            step_pending_q <= 1'b0;
            en_q           <= 1'b0;
            done_q         <= 1'b0;
            led_q          <= '0;
            cnt_q          <= '0;
        end else begin
            sw_s1_q        <= sw;
            sw_s2_q        <= sw_s1_q;
            step_s1_q      <= step_key;
            step_s2_q      <= step_s1_q;
            step_s3_q      <= step_s2_q;
            mode_q         <= mode_d;
            div_q          <= div_d;
            step_pending_q <= step_pending_d;
            en_q           <= en_d;
            done_q         <= done_d;
            led_q          <= led_d;
            cnt_q          <= cnt_d;
        end
    end

endmodule

// File: tb/tb_io_run_ctrl.sv
// Self-checking bench for io_run_ctrl: a register-access vector table plus
// directed sequences for the run modes, counter saturation and the done flag.
module tb_io_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, wd;
    logic        we;
    logic [9:0]  sw;
    logic        step_key, endcontrol;

    logic [31:0] rd;
    logic        is_io, cpu_en, done;
    logic [9:0]  led;
    logic [31:0] cycle_count;

    logic [31:0] rd_s;
    logic        is_io_s, cpu_en_s, done_s;
    logic [9:0]  led_s;
    logic [3:0]  cycle_count_s;

    always #5 clk = ~clk;

    io_run_ctrl #(.DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .wd          (wd),
        .we          (we),
        .rd          (rd),
        .is_io       (is_io),
        .sw          (sw),
        .step_key    (step_key),
        .endcontrol  (endcontrol),
        .cpu_en      (cpu_en),
        .led         (led),
        .cycle_count (cycle_count),
        .done        (done)
    );

    // Narrow counter instance for the saturation check.
    io_run_ctrl #(.DIV(4), .CNT_W(4)) dut_s (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .wd          (wd),
        .we          (we),
        .rd          (rd_s),
        .is_io       (is_io_s),
        .sw          (sw),
        .step_key    (step_key),
        .endcontrol  (endcontrol),
        .cpu_en      (cpu_en_s),
        .led         (led_s),
        .cycle_count (cycle_count_s),
        .done        (done_s)
    );

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_io;
        logic [9:0]  exp_led;
    } vec_t;

    vec_t vecs[13];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pulse;
    int          first;
    int          pend_seen;
    logic [31:0] c0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    // Leaves the bench one step after the last reset edge, reset low.
    task automatic do_reset();
        reset      = 1'b1;
        we         = 1'b0;
        endcontrol = 1'b0;
        a          = '0;
        wd         = '0;
        #1;
        check("cpu_en low while reset", 32'(cpu_en), 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic count_pulses(input int n);
        n_pulse = 0;
        first   = -1;
        for (int j = 0; j < n; j++) begin
            if (cpu_en) begin
                n_pulse++;
                if (first < 0) first = j;
            end
            if (j == 3) check("status pending before step", rd, 32'h2);
            if (j == 4) check("status pending cleared", rd, 32'h0);
            tick();
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h100, 32'h0,        32'h2A5, 1'b1, 10'h000};
        vecs[1]  = '{1'b1, 32'h104, 32'h3FF,      32'h000, 1'b1, 10'h3FF};
        vecs[2]  = '{1'b0, 32'h104, 32'h0,        32'h3FF, 1'b1, 10'h3FF};
        vecs[3]  = '{1'b1, 32'h004, 32'h0,        32'h000, 1'b0, 10'h3FF};
        vecs[4]  = '{1'b1, 32'h100, 32'h155,      32'h2A5, 1'b1, 10'h3FF};
        vecs[5]  = '{1'b0, 32'h114, 32'h0,        32'h000, 1'b1, 10'h3FF};
        vecs[6]  = '{1'b0, 32'h11C, 32'h0,        32'h000, 1'b1, 10'h3FF};
        vecs[7]  = '{1'b1, 32'h118, 32'h0,        32'h000, 1'b1, 10'h3FF};
        vecs[8]  = '{1'b1, 32'h104, 32'hFFFF_F0AB, 32'h3FF, 1'b1, 10'h0AB};
        vecs[9]  = '{1'b0, 32'h110, 32'h0,        32'h000, 1'b1, 10'h0AB};
        vecs[10] = '{1'b0, 32'h10C, 32'h0,        32'h000, 1'b1, 10'h0AB};
        vecs[11] = '{1'b0, 32'h104, 32'h123,      32'h0AB, 1'b1, 10'h0AB};
        vecs[12] = '{1'b0, 32'h204, 32'h0,        32'h000, 1'b0, 10'h0AB};

        sw       = '0;
        step_key = 1'b0;

        // Reset state and free-run start-up.
        do_reset();
        check("cpu_en first cycle after reset", 32'(cpu_en), 32'h0);
        check("led after reset", 32'(led), 32'h0);
        check("cycle_count after reset", cycle_count, 32'h0);
        check("done after reset", 32'(done), 32'h0);
        tick();
        check("cpu_en second cycle after reset", 32'(cpu_en), 32'h1);
        repeat (99) tick();
        check("cycle_count after 100 cycles", cycle_count, 32'd99);
        check("narrow counter saturated", 32'(cycle_count_s), 32'd15);

        // CYCLE write on an increment cycle: clear wins.
        io_write(32'h108, 32'h0);
        check("cycle clear wins", cycle_count, 32'h0);
        check("narrow counter cleared", 32'(cycle_count_s), 32'h0);
        tick();
        check("cycle resumes after clear", cycle_count, 32'h1);

        // Switch synchroniser latency.
        sw = 10'h2A5;
        a  = 32'h100;
        tick();
        check("sw after 1 cycle", rd, 32'h0);
        tick();
        check("sw after 2 cycles", rd, 32'h2A5);

        // Register access table.
        for (int i = 0; i < 13; i++) begin
            we = vecs[i].we;
            a  = vecs[i].a;
            wd = vecs[i].wd;
            #1;
            check($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d is_io", i), 32'(is_io), 32'(vecs[i].exp_io));
            tick();
            we = 1'b0;
            check($sformatf("vec%0d led", i), 32'(led), 32'(vecs[i].exp_led));
        end

        // Paused mode: enable drops next cycle and writes are ignored.
        io_write(32'h10C, 32'h3);
        check("pause cpu_en next cycle", 32'(cpu_en), 32'h0);
        a = 32'h10C;
        #1;
        check("ctrl readback", rd, 32'h3);
        c0 = cycle_count;
        io_write(32'h104, 32'h155);
        check("led write ignored when paused", 32'(led), 32'h0AB);
        repeat (3) tick();
        check("pause count frozen", cycle_count, c0);
        check("pause cpu_en stays low", 32'(cpu_en), 32'h0);

        // Divided mode, DIV=4: pulses on cycles 4, 8, 12 after the write.
        do_reset();
        tick();
        io_write(32'h10C, 32'h1);
        c0 = cycle_count;
        for (int j = 1; j <= 12; j++) begin
            check($sformatf("div cpu_en cycle %0d", j), 32'(cpu_en), (j % 4 == 0) ? 32'h1 : 32'h0);
            tick();
        end
        check("div count increments", cycle_count, c0 + 32'd3);

        // Single-step: one pulse 4 cycles after a held key rises, then a second press.
        do_reset();
        tick();
        io_write(32'h10C, 32'h2);
        a = 32'h110;
        repeat (3) tick();
        check("step idle cpu_en", 32'(cpu_en), 32'h0);
        step_key = 1'b1;
        count_pulses(50);
        check("step pulse count", n_pulse, 32'd1);
        check("step pulse latency", first, 32'd4);
        step_key = 1'b0;
        repeat (5) tick();
        step_key = 1'b1;
        count_pulses(20);
        check("second step pulse count", n_pulse, 32'd1);
        check("second step pulse latency", first, 32'd4);
        step_key = 1'b0;

        // Key press in free-run mode does not set step_pending.
        do_reset();
        repeat (3) tick();
        a         = 32'h110;
        step_key  = 1'b1;
        pend_seen = 0;
        for (int j = 0; j < 10; j++) begin
            if (rd[1]) pend_seen++;
            tick();
        end
        check("no pending in free-run", pend_seen, 32'd0);
        io_write(32'h10C, 32'h2);
        n_pulse = 0;
        for (int j = 0; j < 8; j++) begin
            if (cpu_en) n_pulse++;
            tick();
        end
        check("no stale step after mode change", n_pulse, 32'd0);
        step_key = 1'b0;

        // Reset while a step is pending drops it.
        do_reset();
        tick();
        io_write(32'h10C, 32'h2);
        a = 32'h110;
        repeat (2) tick();
        step_key = 1'b1;
        repeat (3) tick();
        check("pending before mid-step reset", rd, 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("pending cleared by reset", rd, 32'h0);
        check("no pulse after mid-step reset", 32'(cpu_en), 32'h0);
        step_key = 1'b0;

        // Sticky done.
        do_reset();
        repeat (3) tick();
        endcontrol = 1'b1;
        c0 = cycle_count;
        tick();
        endcontrol = 1'b0;
        a = 32'h110;
        #1;
        check("done set", 32'(done), 32'h1);
        check("no increment on endcontrol", cycle_count, c0);
        check("cpu_en low when done", 32'(cpu_en), 32'h0);
        check("status done", rd, 32'h1);
        repeat (5) tick();
        check("done sticky", 32'(done), 32'h1);
        check("count frozen when done", cycle_count, c0);
        do_reset();
        check("done cleared by reset", 32'(done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
